// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctrl : stall/flush controller for the five-stage pipeline
// Revision 1.0
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int BUS_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic       d_is_md,
  input  logic [4:0] e_regaddr,
  input  logic       e_regwrite,
  input  logic [1:0] e_tnew,
  input  logic [4:0] m_regaddr,
  input  logic       m_regwrite,
  input  logic [1:0] m_tnew,
  input  logic       e_md_start,
  input  logic       e_md_is_div,
  input  logic       m_mem_req,
  input  logic       bus_ready,
  input  logic       exc_req,
  input  logic       eret,
  output logic       stall_f,
  output logic       stall_d,
  output logic       stall_e,
  output logic       stall_m,
  output logic       stall_w,
  output logic       flush_d,
  output logic       flush_e,
  output logic       flush_m,
  output logic       md_busy,
  output logic       bus_err
);

  localparam int c_MD_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int c_MDW    = (c_MD_MAX >= 1) ? $clog2(c_MD_MAX + 1) : 1;
  localparam int c_WW     = (BUS_TIMEOUT >= 1) ? $clog2(BUS_TIMEOUT + 1) : 1;

  localparam logic [c_MDW-1:0] c_MULT_LD = c_MDW'(MULT_CYCLES);
  localparam logic [c_MDW-1:0] c_DIV_LD  = c_MDW'(DIV_CYCLES);
  localparam logic [c_WW-1:0]  c_TO      = c_WW'(BUS_TIMEOUT);
  localparam bit               c_TO_EN   = (BUS_TIMEOUT != 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [c_WW-1:0]  r_wcnt;
  logic [c_WW-1:0]  w_wcnt_nxt;
  logic [c_MDW-1:0] r_md_cnt;
  logic [c_MDW-1:0] w_md_nxt;
  logic             r_md_busy;
  logic             r_bus_err;

  logic w_rs_e, w_rs_m, w_rt_e, w_rt_m;
  logic w_hz_rs, w_hz_rt, w_hz_md, w_stall_data;
  logic w_freeze, w_redirect, w_md_ld;

  // A tuse of 3 marks the operand as unused, so it can never raise a hazard.
  assign w_rs_e  = e_regwrite && (e_regaddr == d_rs) && (e_tnew > d_tuse_rs);
  assign w_rs_m  = m_regwrite && (m_regaddr == d_rs) && (m_tnew > d_tuse_rs);
  assign w_rt_e  = e_regwrite && (e_regaddr == d_rt) && (e_tnew > d_tuse_rt);
  assign w_rt_m  = m_regwrite && (m_regaddr == d_rt) && (m_tnew > d_tuse_rt);
  assign w_hz_rs = (d_rs != 5'd0) && (d_tuse_rs != 2'd3) && (w_rs_e || w_rs_m);
  assign w_hz_rt = (d_rt != 5'd0) && (d_tuse_rt != 2'd3) && (w_rt_e || w_rt_m);
  assign w_hz_md = d_is_md && (r_md_busy || e_md_start);

  assign w_stall_data = w_hz_rs || w_hz_rt || w_hz_md;
  assign w_redirect   = exc_req || eret;
  assign w_freeze     = m_mem_req && !bus_ready && (r_state != S_ERR);

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    case (r_state)
      S_IDLE: begin
        if (m_mem_req && !bus_ready) begin
          w_state_nxt = S_WAIT;
          w_wcnt_nxt  = c_WW'(1);
        end
      end
      S_WAIT: begin
        if (bus_ready) begin
          w_state_nxt = S_IDLE;
        end else if (c_TO_EN && (r_wcnt == c_TO)) begin
          w_state_nxt = S_ERR;
        end else begin
          w_wcnt_nxt = r_wcnt + 1'b1;
        end
      end
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A frozen start is re-presented later; a start alongside a redirect is dropped.
  assign w_md_ld = e_md_start && !w_freeze && !w_redirect;

  always_comb begin
    w_md_nxt = r_md_cnt;
    if (w_md_ld) begin
      w_md_nxt = e_md_is_div ? c_DIV_LD : c_MULT_LD;
    end else if (r_md_cnt != '0) begin
      w_md_nxt = r_md_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_wcnt    <= '0;
      r_md_cnt  <= '0;
      r_md_busy <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wcnt    <= w_wcnt_nxt;
      r_md_cnt  <= w_md_nxt;
      r_md_busy <= (w_md_nxt != '0);
      r_bus_err <= (w_state_nxt == S_ERR);
    end
  end

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    stall_w = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    if (!reset) begin
      stall_f = 1'b0;
    end else if (w_freeze) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      stall_w = 1'b1;
    end else if (w_redirect) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_m = 1'b1;
    end else if (w_stall_data) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  assign md_busy = r_md_busy;
  assign bus_err = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pipe_hazard_ctrl : scoreboard bench for pipe_hazard_ctrl
// Revision 1.0
// ============================================================================
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] d_rs, d_rt, e_regaddr, m_regaddr;
  logic [1:0] d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
  logic       d_is_md, e_regwrite, m_regwrite, e_md_start, e_md_is_div;
  logic       m_mem_req, bus_ready, exc_req, eret;
  logic       stall_f, stall_d, stall_e, stall_m, stall_w;
  logic       flush_d, flush_e, flush_m, md_busy, bus_err;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10),
    .BUS_TIMEOUT(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_is_md    (d_is_md),
    .e_regaddr  (e_regaddr),
    .e_regwrite (e_regwrite),
    .e_tnew     (e_tnew),
    .m_regaddr  (m_regaddr),
    .m_regwrite (m_regwrite),
    .m_tnew     (m_tnew),
    .e_md_start (e_md_start),
    .e_md_is_div(e_md_is_div),
    .m_mem_req  (m_mem_req),
    .bus_ready  (bus_ready),
    .exc_req    (exc_req),
    .eret       (eret),
    .stall_f    (stall_f),
    .stall_d    (stall_d),
    .stall_e    (stall_e),
    .stall_m    (stall_m),
    .stall_w    (stall_w),
    .flush_d    (flush_d),
    .flush_e    (flush_e),
    .flush_m    (flush_m),
    .md_busy    (md_busy),
    .bus_err    (bus_err)
  );

  // {stall_f,d,e,m,w, flush_d,e,m, md_busy, bus_err}
  logic [9:0] w_obs;
  assign w_obs = {stall_f, stall_d, stall_e, stall_m, stall_w,
                  flush_d, flush_e, flush_m, md_busy, bus_err};

  localparam logic [9:0] c_Z   = 10'b00000_000_0_0;
  localparam logic [9:0] c_DST = 10'b11000_010_0_0;
  localparam logic [9:0] c_FRZ = 10'b11111_000_0_0;
  localparam logic [9:0] c_FLU = 10'b00000_111_0_0;
  localparam logic [9:0] c_BSY = 10'b00000_000_1_0;
  localparam logic [9:0] c_ERR = 10'b00000_000_0_1;

  typedef struct {
    string      tag;
    logic [9:0] exp;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_eq(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [9:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic step(input string tag, input logic [9:0] exp);
    push_exp(tag, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    d_rs = 5'd0; d_rt = 5'd0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3; d_is_md = 1'b0;
    e_regaddr = 5'd0; e_regwrite = 1'b0; e_tnew = 2'd0;
    m_regaddr = 5'd0; m_regwrite = 1'b0; m_tnew = 2'd0;
    e_md_start = 1'b0; e_md_is_div = 1'b0;
    m_mem_req = 1'b0; bus_ready = 1'b1; exc_req = 1'b0; eret = 1'b0;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      m_e = sb.pop_front();
      check_eq(m_e.tag, w_obs, m_e.exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    clr();
    d_rs = 5'd8; d_tuse_rs = 2'd1; e_regwrite = 1'b1; e_regaddr = 5'd8; e_tnew = 2'd2;
    m_mem_req = 1'b1; bus_ready = 1'b0; exc_req = 1'b1;
    @(posedge clk);
    #1;
    step("rst_hold0", c_Z);
    step("rst_hold1", c_Z);
    clr();
    reset = 1'b1;
    step("idle", c_Z);

    d_rs = 5'd8; d_tuse_rs = 2'd1; e_regwrite = 1'b1; e_regaddr = 5'd8; e_tnew = 2'd2;
    step("lu_e", c_DST);
    clr();
    d_rs = 5'd8; d_tuse_rs = 2'd1; m_regwrite = 1'b1; m_regaddr = 5'd8; m_tnew = 2'd1;
    step("lu_m", c_Z);
    clr();
    d_tuse_rs = 2'd1; e_regwrite = 1'b1; e_tnew = 2'd2;
    step("rs_zero", c_Z);
    clr();
    d_rt = 5'd9; d_tuse_rt = 2'd0; m_regwrite = 1'b1; m_regaddr = 5'd9; m_tnew = 2'd2;
    step("rt_m", c_DST);
    d_tuse_rt = 2'd2;
    step("rt_eq", c_Z);
    clr();
    d_rt = 5'd9; d_tuse_rt = 2'd3; e_regwrite = 1'b1; e_regaddr = 5'd9; e_tnew = 2'd3;
    step("rt_unused", c_Z);
    d_tuse_rt = 2'd2;
    step("rt_e3", c_DST);
    e_regwrite = 1'b0;
    step("rt_nowr", c_Z);

    clr();
    e_md_start = 1'b1; e_md_is_div = 1'b1; d_is_md = 1'b1;
    step("div_start", c_DST);
    e_md_start = 1'b0; e_md_is_div = 1'b0;
    for (int i = 0; i < 10; i++) step("div_busy", c_DST | c_BSY);
    step("div_done", c_Z);
    clr();
    e_md_start = 1'b1;
    step("mul_start", c_Z);
    clr();
    for (int i = 0; i < 5; i++) step("mul_busy", c_BSY);
    step("mul_done", c_Z);

    m_mem_req = 1'b1; bus_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("bw_frz", c_FRZ);
    bus_ready = 1'b1;
    step("bw_done", c_Z);
    clr();
    step("bw_idle", c_Z);

    m_mem_req = 1'b1; bus_ready = 1'b0;
    for (int i = 0; i < 5; i++) step("to_frz", c_FRZ);
    step("to_err", c_ERR);
    step("to_refrz", c_FRZ);
    m_mem_req = 1'b0; bus_ready = 1'b1;
    step("to_rel", c_Z);
    step("to_idle", c_Z);

    clr();
    exc_req = 1'b1;
    d_rs = 5'd8; d_tuse_rs = 2'd1; e_regwrite = 1'b1; e_regaddr = 5'd8; e_tnew = 2'd2;
    e_md_start = 1'b1; e_md_is_div = 1'b1; d_is_md = 1'b1;
    step("exc_all", c_FLU);
    clr();
    step("exc_noload", c_Z);
    eret = 1'b1;
    step("eret", c_FLU);
    exc_req = 1'b1;
    step("exc_eret", c_FLU);
    clr();
    exc_req = 1'b1; m_mem_req = 1'b1; bus_ready = 1'b0; e_md_start = 1'b1;
    step("exc_frz", c_FRZ);
    clr();
    step("frz_noload", c_Z);

    e_md_start = 1'b1; e_md_is_div = 1'b1;
    step("r_start", c_Z);
    clr();
    step("r_busy0", c_BSY);
    step("r_busy1", c_BSY);
    m_mem_req = 1'b1; bus_ready = 1'b0;
    step("r_frz", c_FRZ | c_BSY);
    push_exp("r_wait", c_FRZ | c_BSY);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_eq("rst_async", w_obs, c_Z);
    @(posedge clk);
    #1;
    clr();
    bus_ready = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) step("post_rst", c_Z);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the five-stage pipeline. Drives the stall and flush inputs of the F/D, D/E, E/M and M/W pipeline registers.
- Arbitrates between four sources: register data hazards, multi-cycle multiply/divide occupancy, data-bus wait states with timeout, and CP0 exception/eret redirects.
- Holds the only sequential pipeline-control state: the MDU busy counter and the bus-wait FSM.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu.
- DIV_CYCLES, 10, busy cycles for div/divu.
- BUS_TIMEOUT, 16, max consecutive not-ready cycles before bus_err. 0 disables the timeout.

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low reset
- d_rs  in  5  D-stage rs address
- d_rt  in  5  D-stage rt address
- d_tuse_rs  in  2  cycles until rs is needed (0..2; 3 = unused)
- d_tuse_rt  in  2  same for rt
- d_is_md  in  1  D instr touches MDU/HI/LO
- e_regaddr  in  5  E-stage destination
- e_regwrite  in  1  E-stage writes a register
- e_tnew  in  2  cycles until E result is available
- m_regaddr  in  5  M-stage destination
- m_regwrite  in  1  M-stage writes a register
- m_tnew  in  2  cycles until M result is available
- e_md_start  in  1  E instr starts an MDU op
- e_md_is_div  in  1  started op is a divide
- m_mem_req  in  1  M instr accesses the data bus
- bus_ready  in  1  bus completes the access this cycle
- exc_req  in  1  CP0 takes an exception/interrupt for the M instr
- eret  in  1  M instr is eret
- stall_f  out  1  hold PC
- stall_d  out  1  hold F/D
- stall_e  out  1  hold D/E
- stall_m  out  1  hold E/M
- stall_w  out  1  hold M/W
- flush_d  out  1  clear F/D
- flush_e  out  1  clear D/E (bubble)
- flush_m  out  1  clear E/M
- md_busy  out  1  MDU occupied (registered)
- bus_err  out  1  one-cycle bus timeout pulse (registered)

Behaviour:
- Reset (reset=0, async): MDU count=0, FSM=IDLE, wait count=0, md_busy=0, bus_err=0. While reset is low, all stall/flush outputs are forced to 0.

Hazard terms (combinational):
- hz_rs = d_rs≠0 && ((e_regwrite && e_regaddr==d_rs && e_tnew>d_tuse_rs) || (m_regwrite && m_regaddr==d_rs && m_tnew>d_tuse_rs)). d_tuse_rs=3 never matches.
- hz_rt is defined the same way using rt.
- hz_md = d_is_md && (md_busy || e_md_start).
- stall_data = hz_rs | hz_rt | hz_md.

Bus FSM:
- IDLE: m_mem_req && !bus_ready → WAIT, wait count=1. Otherwise stay.
- WAIT: bus_ready → IDLE.
- WAIT: else if BUS_TIMEOUT≠0 && count==BUS_TIMEOUT → ERR.
- WAIT: else count+1.
- ERR: bus_err=1 for exactly this cycle, freeze released, → IDLE unconditionally.
- freeze = m_mem_req && !bus_ready && state≠ERR.

Output priority (highest first):
1. freeze: all five stalls=1, all flushes=0.
2. exc_req|eret: flush_d=flush_e=flush_m=1, all stalls=0. eret and exc_req together behave as exc_req.
3. stall_data: stall_f=stall_d=1, flush_e=1, others 0.
4. Otherwise all 0.

MDU counter:
- Load when e_md_start && !freeze && !(exc_req|eret): count = e_md_is_div ? DIV_CYCLES : MULT_CYCLES.
- A start while frozen is ignored; E is held, so the start is re-presented.
- A start coincident with an exception is dropped.
- When count≠0 and no load, count−1 each cycle. Counting continues during freeze and during exceptions; an in-flight op is not cancelled.
- md_busy = (next count ≠ 0), registered. It rises the cycle after the start and falls after exactly N busy cycles.
- A start while busy cannot occur, because hz_md holds the MDU instr in D. If it does occur, the reload wins.
- Counter width ≥ clog2(max(MULT_CYCLES,DIV_CYCLES)+1). Wait counter width ≥ clog2(BUS_TIMEOUT+1).

Test Plan:
- lw $8 in E (e_tnew=2), D uses $8 with tuse_rs=1 → stall_f=stall_d=flush_e=1 for 1 cycle. With d_rs=0 under the same conditions → no stall.
- div start (DIV_CYCLES=10), then mflo in D → md_busy high 10 cycles, stall_d high through the last busy cycle, released the cycle md_busy falls. mult gives 5 cycles.
- m_mem_req=1, bus_ready low 3 cycles → all stalls=1 for exactly 3 cycles, no flush, FSM returns to IDLE, bus_err never asserts.
- bus_ready held low, BUS_TIMEOUT=4 → freeze for 5 cycles (IDLE cycle + 4 WAIT), then one cycle with bus_err=1 and stalls=0, then IDLE.
- exc_req coincident with a data hazard and e_md_start → flush_d/e/m=1, stalls=0, MDU not loaded. With freeze active in the same cycle → freeze wins: stalls=1, flushes=0.
- Reset dropped mid-WAIT with MDU count=7 → outputs 0 immediately (async). After release: md_busy=0, FSM IDLE.
